// File: rtl/dds_pkg.sv
// -----------------------------------------------------------------------------
// dds_pkg
// Shared definitions for the multi-channel DDS phase accumulator and its
// sequential tuning-word divider.
//   - CLK_FREQ_DEFAULT / PHASE_BITS_DEFAULT : default build parameters
//   - fsm_state_t + IDLE/DIVIDE/COMMIT      : config-port FSM encoding
//   - tuning_word_t                         : tuning word at default width
//   - max_int()                             : elaboration-time helper
// -----------------------------------------------------------------------------
package dds_pkg;

  localparam int CLK_FREQ_DEFAULT   = 100_000_000;
  localparam int PHASE_BITS_DEFAULT = 32;

  // Config FSM encoding, kept as plain constants so older blocks that compare
  // against raw state codes keep working.
  typedef logic [1:0] fsm_state_t;
  localparam fsm_state_t IDLE   = 2'd0;
  localparam fsm_state_t DIVIDE = 2'd1;
  localparam fsm_state_t COMMIT = 2'd2;

  typedef logic [PHASE_BITS_DEFAULT-1:0] tuning_word_t;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/tw_seq_divider.sv
// -----------------------------------------------------------------------------
// tw_seq_divider
// Restoring divider computing quotient = floor(dividend * 2^QUOT_BITS / DIVISOR)
// one quotient bit per clock, QUOT_BITS clocks per division. Requires
// dividend < DIVISOR, which keeps the partial remainder below DIVISOR.
//
// Ports:
//   clock, reset   : clock, asynchronous active-high reset
//   start          : begin a division (ignored while busy)
//   dividend       : numerator, sampled on the start edge
//   busy           : division in progress
//   done           : high during the final step; quotient is final from the
//                    following cycle and holds until the next start
//   quotient       : result
// -----------------------------------------------------------------------------
module tw_seq_divider
  import dds_pkg::*;
#(
  parameter int DIVIDEND_BITS = 16,
  parameter int QUOT_BITS     = PHASE_BITS_DEFAULT,
  parameter int DIVISOR       = CLK_FREQ_DEFAULT
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     start,
  input  logic [DIVIDEND_BITS-1:0] dividend,
  output logic                     busy,
  output logic                     done,
  output logic [QUOT_BITS-1:0]     quotient
);

  // The remainder always stays below DIVISOR, but it must also hold the raw
  // dividend on the start edge; the doubled value needs one more bit.
  localparam int REM_BITS = max_int($clog2(DIVISOR), DIVIDEND_BITS + 1);
  localparam int R2_BITS  = REM_BITS + 1;
  localparam int CNT_BITS = max_int($clog2(QUOT_BITS), 1);

  localparam logic [CNT_BITS-1:0] LAST_STEP = CNT_BITS'(QUOT_BITS - 1);
  localparam logic [R2_BITS-1:0]  DIVISOR_W = R2_BITS'(DIVISOR);

  logic [REM_BITS-1:0] rem;
  logic [CNT_BITS-1:0] step;
  logic [R2_BITS-1:0]  r2;
  logic                take;

  assign r2   = {rem, 1'b0};
  assign take = (r2 >= DIVISOR_W);
  assign done = busy && (step == LAST_STEP);

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      busy     <= 1'b0;
      rem      <= '0;
      step     <= '0;
      quotient <= '0;
    end else if (start && !busy) begin
      busy     <= 1'b1;
      rem      <= REM_BITS'(dividend);
      step     <= '0;
      quotient <= '0;
    end else if (busy) begin
      // When not taken, r2 < DIVISOR so truncating to REM_BITS loses nothing.
      rem      <= take ? REM_BITS'(r2 - DIVISOR_W) : REM_BITS'(r2);
      quotient <= {quotient[QUOT_BITS-2:0], take};
      step     <= step + 1'b1;
      if (done) begin
        busy <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/dds_multi_phase_accumulator.sv
// -----------------------------------------------------------------------------
// dds_multi_phase_accumulator
// NUM_CH independent DDS phase accumulators. Frequencies (Hz) arrive over a
// valid/ready config port and are turned into tuning words by a shared
// sequential divider (tw = floor(freq * 2^PHASE_BITS / CLK_FREQ)).
//
// Ports:
//   clock, reset  : clock, asynchronous active-high reset
//   sync          : clears every accumulator on the same edge (phase align)
//   cfg_valid/cfg_ready : config handshake; ready drops for the PHASE_BITS+1
//                   cycles of divide + commit after each accepted request
//   cfg_ch        : target channel (>= NUM_CH is accepted but writes nothing)
//   cfg_freq      : frequency in Hz
//   cfg_offset    : phase offset added to the accumulator on the output
//   phase_out     : channel n at [n*PHASE_BITS +: PHASE_BITS], acc + offset,
//                   one register stage behind the accumulator
//   wrap          : per-channel carry-out pulse of the accumulator add
//
// Build option TW_READBACK_EN (`define) adds:
//   rd_ch         : channel whose tuning word is read back
//   rd_tw         : registered tuning word of rd_ch (0 when out of range)
// -----------------------------------------------------------------------------
module dds_multi_phase_accumulator
  import dds_pkg::*;
#(
  parameter int NUM_CH     = 4,
  parameter int PHASE_BITS = PHASE_BITS_DEFAULT,
  parameter int FREQ_BITS  = 16,
  parameter int CLK_FREQ   = CLK_FREQ_DEFAULT,
  parameter int CH_BITS    = 2
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         sync,
  input  logic                         cfg_valid,
  output logic                         cfg_ready,
  input  logic [CH_BITS-1:0]           cfg_ch,
  input  logic [FREQ_BITS-1:0]         cfg_freq,
  input  logic [PHASE_BITS-1:0]        cfg_offset,
`ifdef TW_READBACK_EN
  input  logic [CH_BITS-1:0]           rd_ch,
  output logic [PHASE_BITS-1:0]        rd_tw,
`endif
  output logic [NUM_CH*PHASE_BITS-1:0] phase_out,
  output logic [NUM_CH-1:0]            wrap
);

  fsm_state_t              state;
  logic [CH_BITS-1:0]      lat_ch;
  logic [PHASE_BITS-1:0]   lat_offset;

  logic                    div_start;
  logic                    div_busy;
  logic                    div_done;
  logic [PHASE_BITS-1:0]   div_quotient;

  logic [PHASE_BITS-1:0]   tw  [NUM_CH];
  logic [PHASE_BITS-1:0]   off [NUM_CH];
  logic [PHASE_BITS-1:0]   acc [NUM_CH];
  logic [PHASE_BITS:0]     sum [NUM_CH];

  assign div_start = (state == IDLE) && cfg_valid && cfg_ready;

  tw_seq_divider #(
    .DIVIDEND_BITS (FREQ_BITS),
    .QUOT_BITS     (PHASE_BITS),
    .DIVISOR       (CLK_FREQ)
  ) u_divider (
    .clock    (clock),
    .reset    (reset),
    .start    (div_start),
    .dividend (cfg_freq),
    .busy     (div_busy),
    .done     (div_done),
    .quotient (div_quotient)
  );

  // Config FSM. cfg_ready is registered so it comes up on the first edge
  // after reset and drops on the accept edge itself.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      cfg_ready  <= 1'b0;
      lat_ch     <= '0;
      lat_offset <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (div_start) begin
            lat_ch     <= cfg_ch;
            lat_offset <= cfg_offset;
            cfg_ready  <= 1'b0;
            state      <= DIVIDE;
          end else begin
            cfg_ready  <= 1'b1;
          end
        end
        DIVIDE: begin
          // The divider's last step coincides with the move to COMMIT, so the
          // quotient is final during the COMMIT cycle.
          if (div_done) begin
            state <= COMMIT;
          end else if (!div_busy) begin
            state     <= IDLE;
            cfg_ready <= 1'b1;
          end
        end
        COMMIT: begin
          state     <= IDLE;
          cfg_ready <= 1'b1;
        end
        default: begin
          state     <= IDLE;
          cfg_ready <= 1'b0;
        end
      endcase
    end
  end

  // NOTE: the per-channel register files are small flop arrays rather than
  // RAM, so they can and do take the asynchronous reset like any other state.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int n = 0; n < NUM_CH; n++) begin
        tw[n]  <= '0;
        off[n] <= '0;
      end
    end else if (state == COMMIT) begin
      // Out-of-range channels match no entry and leave the files untouched.
      for (int n = 0; n < NUM_CH; n++) begin
        if (lat_ch == CH_BITS'(n)) begin
          tw[n]  <= div_quotient;
          off[n] <= lat_offset;
        end
      end
    end
  end

  always_comb begin
    for (int n = 0; n < NUM_CH; n++) begin
      sum[n] = {1'b0, acc[n]} + {1'b0, tw[n]};
    end
  end

  // Accumulators, wrap flags and output stage. sync only clears acc/wrap; the
  // output stage keeps registering acc + off so it shows the offset one edge
  // after the clear.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wrap      <= '0;
      phase_out <= '0;
      for (int n = 0; n < NUM_CH; n++) begin
        acc[n] <= '0;
      end
    end else begin
      for (int n = 0; n < NUM_CH; n++) begin
        if (sync) begin
          acc[n]  <= '0;
          wrap[n] <= 1'b0;
        end else begin
          acc[n]  <= sum[n][PHASE_BITS-1:0];
          wrap[n] <= sum[n][PHASE_BITS];
        end
        phase_out[n*PHASE_BITS +: PHASE_BITS] <= acc[n] + off[n];
      end
    end
  end

`ifdef TW_READBACK_EN
  logic [PHASE_BITS-1:0] rd_sel;

  always_comb begin
    rd_sel = '0;
    for (int n = 0; n < NUM_CH; n++) begin
      if (rd_ch == CH_BITS'(n)) begin
        rd_sel = tw[n];
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rd_tw <= '0;
    end else begin
      rd_tw <= rd_sel;
    end
  end
`endif

endmodule
